// File: rtl/mux_pkg.sv
// Shared types and sizing for the 4-channel multiplexer scan controller.
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/mux_scan_timer.sv
// Settle counter: counts SETTLE_CYCLES cycles of enable, raising tc on the last one.
module mux_scan_timer
  import mux_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of the order the blocks evaluate.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks the select lines of an external 4-to-1 mux, waits for each channel to
// settle, captures mux_out into a 4-bit frame and hands it over with valid/ack.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cont,
  input  logic              mux_out,
  input  logic              ack,
  output logic              s0,
  output logic              s1,
  output logic [NUM_CH-1:0] sample,
  output logic              valid,
  output logic              busy
);

  state_t            state, state_next;
  logic [SEL_W-1:0]  ch, ch_next;
  logic [NUM_CH-1:0] sample_next;
  logic              valid_next;
  logic              settle_done;

  // The counter only runs in SETTLE and sits at zero otherwise, so every
  // entry into SETTLE starts a fresh settle window.
  mux_scan_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state != SETTLE),
    .enable(state == SETTLE),
    .tc    (settle_done)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    ch_next     = ch;
    sample_next = sample;
    valid_next  = valid;
    unique case (state)
      IDLE: begin
        if (start) begin
          ch_next    = '0;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_done) state_next = CAPTURE;
      end
      CAPTURE: begin
        sample_next[ch] = mux_out;
        if (ch == SEL_W'(NUM_CH - 1)) begin
          valid_next = 1'b1;
          ch_next    = '0;
          state_next = DONE;
        end else begin
          ch_next    = ch + 1'b1;
          state_next = SETTLE;
        end
      end
      DONE: begin
        // start is deliberately not looked at here; only ack/cont decide.
        if (ack) begin
          valid_next = 1'b0;
          state_next = cont ? SETTLE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ch     <= '0;
      sample <= '0;
      valid  <= 1'b0;
    end else begin
      state  <= state_next;
      ch     <= ch_next;
      sample <= sample_next;
      valid  <= valid_next;
    end
  end

  assign s0   = ch[0];
  assign s1   = ch[1];
  assign busy = (state == SETTLE) || (state == CAPTURE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: a behavioural mux feeds the DUT and a
// frame/timing model derived from the scan rules predicts every output.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, cont, ack;
  logic       s0, s1, valid, busy;
  logic [3:0] sample, data;
  logic       mux_out;

  // Second instance with the shortest settle window.
  logic       start_f, cont_f, ack_f;
  logic       s0_f, s1_f, valid_f, busy_f;
  logic [3:0] sample_f, data_f;
  logic       mux_out_f;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] frame;  // last frame the model expects the default DUT to hold

  always #5 clk = ~clk;

  assign mux_out   = data[{s1, s0}];
  assign mux_out_f = data_f[{s1_f, s0_f}];

  mux_scan_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .mux_out(mux_out),
    .ack(ack), .s0(s0), .s1(s1), .sample(sample), .valid(valid), .busy(busy)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut_f (
    .clk(clk), .reset(reset), .start(start_f), .cont(cont_f), .mux_out(mux_out_f),
    .ack(ack_f), .s0(s0_f), .s1(s1_f), .sample(sample_f), .valid(valid_f), .busy(busy_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that launched a scan (start or ack+cont).
  // Each channel spans 3 cycles; channel c is captured at edge 3*(c+1).
  task automatic observe_scan(input logic [3:0] d, input bit noise);
    for (int i = 0; i < 12; i++) begin
      logic [1:0] exp_sel;
      logic [3:0] exp_smp;
      int         done_ch;
      done_ch = i / 3;
      exp_sel = 2'(done_ch);
      for (int b = 0; b < 4; b++) exp_smp[b] = (b < done_ch) ? d[b] : frame[b];
      checks++;
      if ({s1, s0} !== exp_sel) begin
        failures++;
        $display("FAIL scan_sel edge=%0d: got %b want %b", i, {s1, s0}, exp_sel);
      end
      checks++;
      if (valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL scan_flags edge=%0d: got valid=%b busy=%b want valid=0 busy=1", i, valid, busy);
      end
      checks++;
      if (sample !== exp_smp) begin
        failures++;
        $display("FAIL scan_partial edge=%0d: got %b want %b", i, sample, exp_smp);
      end
      if (noise) begin
        start = 1'($urandom);
        ack   = 1'($urandom);
      end
      tick();
    end
    start = 1'b0;
    ack   = 1'b0;
    checks++;
    if (valid !== 1'b1 || busy !== 1'b0 || {s1, s0} !== 2'b00) begin
      failures++;
      $display("FAIL scan_done: got valid=%b busy=%b sel=%b want valid=1 busy=0 sel=00",
               valid, busy, {s1, s0});
    end
    checks++;
    if (sample !== d) begin
      failures++;
      $display("FAIL scan_frame: got %b want %b", sample, d);
    end
    frame = d;
  endtask

  task automatic release_frame();
    cont = 1'b0;
    ack  = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL release: got valid=%b busy=%b want 0 0", valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; ack = 1'b1; cont = 1'b1;
    start_f = 1'b0; ack_f = 1'b0; cont_f = 1'b0;
    data = 4'b0000; data_f = 4'b0000;
    tick();
    tick();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || sample !== 4'b0000 || {s1, s0} !== 2'b00) begin
      failures++;
      $display("FAIL reset_state: got valid=%b busy=%b sample=%b sel=%b want 0 0 0000 00",
               valid, busy, sample, {s1, s0});
    end
    reset = 1'b0; start = 1'b0; ack = 1'b0; cont = 1'b0;
    frame = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold cycle=%0d: got busy=%b valid=%b want 0 0", i, busy, valid);
      end
    end
  endtask

  task automatic test_basic_scan();
    data  = 4'b1010;
    start = 1'b1;
    tick();
    start = 1'b0;
    observe_scan(4'b1010, 1'b0);
  endtask

  task automatic test_hold_ack();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || sample !== 4'b1010) begin
        failures++;
        $display("FAIL hold_frame cycle=%0d: got valid=%b sample=%b want 1 1010", i, valid, sample);
      end
    end
    release_frame();
    tick();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || {s1, s0} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_ack: got busy=%b valid=%b sel=%b want 0 0 00", busy, valid, {s1, s0});
    end
  endtask

  task automatic test_continuous();
    start = 1'b1;
    tick();
    start = 1'b0;
    observe_scan(4'b1010, 1'b0);
    data = 4'b0101;
    tick();
    checks++;
    if (sample !== 4'b1010 || valid !== 1'b1) begin
      failures++;
      $display("FAIL done_stable: got sample=%b valid=%b want 1010 1", sample, valid);
    end
    cont = 1'b1;
    ack  = 1'b1;
    tick();
    ack  = 1'b0;
    cont = 1'b0;
    observe_scan(4'b0101, 1'b0);
    // start alongside ack with cont=0 must end in IDLE, not a new scan
    start = 1'b1;
    ack   = 1'b1;
    tick();
    start = 1'b0;
    ack   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        failures++;
        $display("FAIL start_ack_done cycle=%0d: got busy=%b valid=%b want 0 0", i, busy, valid);
      end
      tick();
    end
  endtask

  task automatic test_reset_midscan();
    logic [3:0] d;
    data  = 4'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    checks++;
    if ({s1, s0} !== 2'b10 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midscan_pos: got sel=%b busy=%b want 10 1", {s1, s0}, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (sample !== 4'b0000 || valid !== 1'b0 || busy !== 1'b0 || {s1, s0} !== 2'b00) begin
      failures++;
      $display("FAIL midscan_reset: got sample=%b valid=%b busy=%b sel=%b want 0000 0 0 00",
               sample, valid, busy, {s1, s0});
    end
    frame = 4'b0000;
    tick();
    d     = 4'($urandom);
    data  = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    observe_scan(d, 1'b0);
    release_frame();
  endtask

  task automatic test_random_noise();
    for (int n = 0; n < 4; n++) begin
      logic [3:0] d;
      d     = 4'($urandom);
      data  = d;
      start = 1'b1;
      tick();
      observe_scan(d, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
      release_frame();
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_fast_settle();
    for (int n = 0; n < 2; n++) begin
      logic [3:0] d;
      int         lat;
      d       = 4'($urandom);
      data_f  = d;
      start_f = 1'b1;
      tick();
      start_f = 1'b0;
      lat     = 0;
      while (valid_f !== 1'b1 && lat < 40) begin
        checks++;
        if ({s1_f, s0_f} !== 2'(lat / 2)) begin
          failures++;
          $display("FAIL fast_sel edge=%0d: got %b want %b", lat, {s1_f, s0_f}, 2'(lat / 2));
        end
        tick();
        lat++;
      end
      checks++;
      if (lat != 8) begin
        failures++;
        $display("FAIL fast_latency: got %0d want 8", lat);
      end
      checks++;
      if (sample_f !== d) begin
        failures++;
        $display("FAIL fast_frame: got %b want %b", sample_f, d);
      end
      ack_f = 1'b1;
      tick();
      ack_f = 1'b0;
      checks++;
      if (valid_f !== 1'b0 || busy_f !== 1'b0) begin
        failures++;
        $display("FAIL fast_release: got valid=%b busy=%b want 0 0", valid_f, busy_f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_hold_ack();
    test_continuous();
    test_reset_midscan();
    test_random_noise();
    test_fast_settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles the select lines are held stable before each capture; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request one 4-channel scan; sampled only in IDLE.
REQ-005 SHALL have port cont, input, 1: continuous mode; when high at ack, a new scan begins immediately.
REQ-006 SHALL have port mux_out, input, 1: selected data bit returned from the downstream 4-to-1 multiplexer.
REQ-007 SHALL have port s0, output, 1: select LSB driven to the multiplexer.
REQ-008 SHALL have port s1, output, 1: select MSB driven to the multiplexer.
REQ-009 SHALL have port sample, output, 4: captured frame; bit n holds the value of channel n (i0..i3).
REQ-010 SHALL have port valid, output, 1: sample holds a complete frame that is not yet acknowledged.
REQ-011 SHALL have port ack, input, 1: consumer accepts the frame; effective only while valid=1.
REQ-012 SHALL have port busy, output, 1: high whenever the state is SETTLE or CAPTURE.

Function
REQ-013 SHALL implement the states IDLE, SETTLE, CAPTURE and DONE; the 2-bit channel index ch drives {s1,s0}=ch directly from a register.
REQ-014 IDLE & start=1 SHALL give ch<=0, settle counter<=0, state<=SETTLE; IDLE & start=0 SHALL hold.
REQ-015 SETTLE SHALL increment the counter each cycle and SHALL move to CAPTURE on the cycle the counter reaches SETTLE_CYCLES-1.
REQ-016 CAPTURE SHALL last exactly 1 cycle and write sample[ch]<=mux_out.
REQ-016a CAPTURE with ch<3 SHALL do ch<=ch+1, counter<=0, state<=SETTLE.
REQ-016b CAPTURE with ch=3 SHALL do valid<=1, state<=DONE, ch<=0 (no wrap to a 5th channel).
REQ-017 Each channel SHALL occupy SETTLE_CYCLES+1 cycles; valid SHALL rise exactly 4*(SETTLE_CYCLES+1) rising edges after the edge that sampled start (12 for the default).
REQ-018 sample SHALL only change in CAPTURE; the bits of a partial scan overwrite the old frame bit by bit, and valid=0 throughout the scan.
REQ-019 DONE SHALL hold valid=1 and sample stable until ack=1.
REQ-019a On ack: valid<=0; state<=SETTLE if cont=1, else IDLE.
REQ-020 ack while valid=0 SHALL be ignored; start outside IDLE SHALL be ignored; start and ack together in DONE SHALL be governed by ack/cont only.
REQ-021 {s1,s0} SHALL NOT change during SETTLE or CAPTURE of a channel; they change only on the CAPTURE->SETTLE and DONE/IDLE transitions.

Reset
REQ-022 reset=1 SHALL, at the next rising edge and from any state (including mid-scan), force state=IDLE, ch=0 (s1=s0=0), counter=0, sample=4'b0000, valid=0, busy=0.
REQ-023 reset SHALL take priority over start, ack and all state transitions in the same cycle.

Structure
REQ-024 A shared package mux_pkg SHALL hold the state enum (IDLE, SETTLE, CAPTURE, DONE), NUM_CH=4, SEL_W=2 and CNT_W=4.
REQ-025 The settle counter SHALL be a single sub-module mux_scan_timer (inputs clear/enable, terminal-count output); all other logic stays in mux_scan_ctrl.
REQ-026 The multiplexer itself SHALL NOT be instantiated inside this block; s0/s1/mux_out connect at the parent level.

Verification
REQ-027 Default params, mux data i3..i0=4'b1010 via a bench model, single start pulse -> valid rises after 12 edges, sample=4'b1010, {s1,s0} sequence 00,01,10,11, each value held 3 cycles.
REQ-028 After REQ-027, hold ack=0 for 20 cycles -> valid stays 1 and sample stays 4'b1010; then ack=1, cont=0 -> valid=0 and state IDLE next edge.
REQ-029 cont=1, data changes to 4'b0101 during DONE, ack pulse -> a new scan starts without start, and the next frame = 4'b0101 after a further 12 edges.
REQ-030 Assert reset during SETTLE of channel 2 -> next edge sample=0, valid=0, busy=0, {s1,s0}=00; a later start yields a full correct frame.
REQ-031 start held high continuously and pulsed mid-scan, ack pulsed while valid=0 -> no restart, no change to frame timing; SETTLE_CYCLES=1 run -> valid after exactly 8 edges.
